// File: rtl/sram_bank_array_pkg.sv
// -----------------------------------------------------------------------------
// sram_bank_array_pkg
//   Shared definitions for the banked SRAM array: tile geometry defaults,
//   RMW controller state encoding and the grid-size derivations used by the
//   top level and the RMW controller.
//   Optional feature macro: SRAM_BYTE_WEN_EN (byte-masked writes via RMW).
// -----------------------------------------------------------------------------
package sram_bank_array_pkg;

    // Geometry of one spsram macro (32b x 16w).
    localparam int TILE_BW_DEFAULT = 32;
    localparam int TILE_AW_DEFAULT = 4;

    // Masked-write sequencer states; encodings match the macro wrappers.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RMW_RD   = 2'd1,
        ST_RMW_WAIT = 2'd2,
        ST_RMW_WR   = 2'd3
    } rmw_state_e;

    // Number of tile rows: upper address bits select the row.
    function automatic int calc_rows(input int bw_addr, input int tile_aw);
        return 1 << (bw_addr - tile_aw);
    endfunction

    // Number of tile columns: tiles side by side form one data word.
    function automatic int calc_cols(input int bw_data, input int tile_bw);
        return bw_data / tile_bw;
    endfunction

    // Width of the row index; at least one bit so a single-row array still
    // has a legal select signal.
    function automatic int calc_row_w(input int bw_addr, input int tile_aw);
        return (bw_addr > tile_aw) ? (bw_addr - tile_aw) : 1;
    endfunction

endpackage

// File: rtl/spsram.sv
// -----------------------------------------------------------------------------
// spsram
//   Behavioural single-port SRAM tile (default 32b x 16w), stand-in for the
//   hard macro. One-cycle read latency; writes commit on the enabling edge.
//   Ports:
//     i_clk   clock
//     i_cen   chip enable (access happens only when 1)
//     i_oen   output enable (o_data forced to 0 when 0)
//     i_wen   1 = write, 0 = read
//     i_addr  word address
//     i_data  write data
//     o_data  read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module spsram #(
    parameter int BW = 32,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_cen,
    input  logic          i_oen,
    input  logic          i_wen,
    input  logic [AW-1:0] i_addr,
    input  logic [BW-1:0] i_data,
    output logic [BW-1:0] o_data
);

    logic [BW-1:0] mem [2**AW];
    logic [BW-1:0] q;

    // NOTE: the array has no reset: clearing every word would turn the RAM
    // into flops, and the macro it models keeps its contents anyway.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_cen) begin
            if (i_wen) begin
                mem[i_addr] <= i_data;
            end else begin
                q <= mem[i_addr];
            end
        end
    end

    assign o_data = i_oen ? q : '0;

endmodule

// File: rtl/sram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// sram_rmw_ctrl
//   Request front end used when byte-masked writes are enabled
//   (SRAM_BYTE_WEN_EN). Accepts requests, issues direct reads and full
//   writes, and turns partial-mask writes into a read-modify-write sequence
//   IDLE -> RMW_RD -> RMW_WAIT -> RMW_WR -> IDLE with ready held low.
//   Ports:
//     i_clk/i_rstn          clock, async active-low reset
//     i_en                  ready permitted (low during the first cycle after reset)
//     i_req_*               request port (valid, wen, addr, data, ben)
//     o_req_ready           request accepted when valid & ready
//     i_rd_word             tile data of the row addressed by the previous read
//     o_acc_en/wen/addr/data  tile access for this cycle
//     o_ext_rd              an external read was accepted (response expected)
// -----------------------------------------------------------------------------
`ifdef SRAM_BYTE_WEN_EN
module sram_rmw_ctrl
    import sram_bank_array_pkg::*;
#(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic                 i_req_valid,
    input  logic                 i_req_wen,
    input  logic [BW_ADDR-1:0]   i_req_addr,
    input  logic [BW_DATA-1:0]   i_req_data,
    input  logic [BW_DATA/8-1:0] i_req_ben,
    input  logic [BW_DATA-1:0]   i_rd_word,
    output logic                 o_req_ready,
    output logic                 o_acc_en,
    output logic                 o_acc_wen,
    output logic [BW_ADDR-1:0]   o_acc_addr,
    output logic [BW_DATA-1:0]   o_acc_data,
    output logic                 o_ext_rd
);

    localparam int NB = BW_DATA / 8;

    rmw_state_e           state_q, state_d;
    logic [BW_ADDR-1:0]   addr_q;
    logic [BW_DATA-1:0]   data_q;
    logic [NB-1:0]        ben_q;
    logic [BW_DATA-1:0]   rdata_q;
    logic [BW_DATA-1:0]   merged;
    logic                 accept;

    // Byte lanes with an enable take the latched write data, the rest keep
    // the word read back from the tile.
    always_comb begin
        merged = rdata_q;
        for (int k = 0; k < NB; k++) begin
            if (ben_q[k]) begin
                merged[8*k +: 8] = data_q[8*k +: 8];
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        o_req_ready = i_en && (state_q == ST_IDLE);
        accept      = i_req_valid && o_req_ready;
        o_acc_en    = 1'b0;
        o_acc_wen   = 1'b0;
        o_acc_addr  = i_req_addr;
        o_acc_data  = i_req_data;
        o_ext_rd    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!i_req_wen) begin
                        o_acc_en = 1'b1;
                        o_ext_rd = 1'b1;
                    end else if (&i_req_ben) begin
                        o_acc_en  = 1'b1;
                        o_acc_wen = 1'b1;
                    end else if (|i_req_ben) begin
                        state_d = ST_RMW_RD;
                    end
                    // An all-zero mask is accepted and simply dropped.
                end
            end
            ST_RMW_RD: begin
                o_acc_en   = 1'b1;
                o_acc_addr = addr_q;
                state_d    = ST_RMW_WAIT;
            end
            ST_RMW_WAIT: begin
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                o_acc_en   = 1'b1;
                o_acc_wen  = 1'b1;
                o_acc_addr = addr_q;
                o_acc_data = merged;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ben_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= i_req_addr;
                data_q <= i_req_data;
                ben_q  <= i_req_ben;
            end
            // Tile data from the RMW_RD access is on i_rd_word during RMW_WAIT.
            if (state_q == ST_RMW_WAIT) begin
                rdata_q <= i_rd_word;
            end
        end
    end

endmodule
`endif

// File: rtl/sram_bank_array.sv
// -----------------------------------------------------------------------------
// sram_bank_array
//   Banked SRAM of BW_DATA x 2**BW_ADDR built from ROWS x COLS spsram tiles.
//   Upper address bits pick the tile row; the low TILE_AW bits address the
//   word inside the tile. Reads return two cycles after acceptance through a
//   registered row-select pipe and a registered output mux.
//   Optional macro: SRAM_BYTE_WEN_EN enables byte-masked writes (RMW through
//   sram_rmw_ctrl). Without it i_req_ben is ignored and ready stays high.
//   Ports:
//     i_clk, i_rstn            clock, async active-low reset
//     i_req_valid/o_req_ready  request handshake
//     i_req_wen                1 = write, 0 = read
//     i_req_addr               word address
//     i_req_data               write data
//     i_req_ben                byte enables (masked-write builds only)
//     o_rsp_valid              one-cycle pulse with read data
//     o_rsp_data               read data, held between pulses
// -----------------------------------------------------------------------------
module sram_bank_array
    import sram_bank_array_pkg::*;
#(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6,
    parameter int TILE_BW = TILE_BW_DEFAULT,
    parameter int TILE_AW = TILE_AW_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wen,
    input  logic [BW_ADDR-1:0]   i_req_addr,
    input  logic [BW_DATA-1:0]   i_req_data,
    input  logic [BW_DATA/8-1:0] i_req_ben,
    output logic                 o_rsp_valid,
    output logic [BW_DATA-1:0]   o_rsp_data
);

    localparam int ROWS  = calc_rows(BW_ADDR, TILE_AW);
    localparam int COLS  = calc_cols(BW_DATA, TILE_BW);
    localparam int ROW_W = calc_row_w(BW_ADDR, TILE_AW);

    logic                 init_q;
    logic                 acc_en;
    logic                 acc_wen;
    logic [BW_ADDR-1:0]   acc_addr;
    logic [BW_DATA-1:0]   acc_data;
    logic                 ext_rd;
    logic [ROW_W-1:0]     acc_row;
    logic [BW_DATA-1:0]   tile_q [ROWS];
    logic [ROW_W-1:0]     rd_row_q1;
    logic                 rd_vld_q1;
    logic                 rd_vld_q2;
    logic [BW_DATA-1:0]   mux_q;

    // Ready is withheld for the first cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

`ifdef SRAM_BYTE_WEN_EN
    logic [BW_DATA-1:0] rd_word;

    assign rd_word = tile_q[rd_row_q1];

    sram_rmw_ctrl #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) u_rmw_ctrl (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_en        (init_q),
        .i_req_valid (i_req_valid),
        .i_req_wen   (i_req_wen),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .i_req_ben   (i_req_ben),
        .i_rd_word   (rd_word),
        .o_req_ready (o_req_ready),
        .o_acc_en    (acc_en),
        .o_acc_wen   (acc_wen),
        .o_acc_addr  (acc_addr),
        .o_acc_data  (acc_data),
        .o_ext_rd    (ext_rd)
    );
`else
    // Byte enables have no meaning when every write is a full-word write.
    logic ben_unused;
    assign ben_unused  = ^i_req_ben;

    assign o_req_ready = init_q;
    assign acc_en      = i_req_valid && init_q;
    assign acc_wen     = i_req_wen;
    assign acc_addr    = i_req_addr;
    assign acc_data    = i_req_data;
    assign ext_rd      = acc_en && !i_req_wen;
`endif

    assign acc_row = ROW_W'(acc_addr >> TILE_AW);

    // Only the addressed row is enabled; all columns of that row move together.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            spsram #(
                .BW (TILE_BW),
                .AW (TILE_AW)
            ) u_tile (
                .i_clk  (i_clk),
                .i_cen  (acc_en && (acc_row == ROW_W'(r))),
                .i_oen  (1'b1),
                .i_wen  (acc_wen),
                .i_addr (acc_addr[TILE_AW-1:0]),
                .i_data (acc_data[c*TILE_BW +: TILE_BW]),
                .o_data (tile_q[r][c*TILE_BW +: TILE_BW])
            );
        end
    end

    // Read pipe: edge T issues the tile read and records its row, edge T+1
    // registers the selected row's data, edge T+2 presents it. The row is
    // tracked for internal RMW reads too, but only external reads carry a
    // valid bit down the pipe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_row_q1   <= '0;
            rd_vld_q1   <= 1'b0;
            rd_vld_q2   <= 1'b0;
            mux_q       <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            if (acc_en && !acc_wen) begin
                rd_row_q1 <= acc_row;
            end
            rd_vld_q1 <= ext_rd;
            rd_vld_q2 <= rd_vld_q1;
            if (rd_vld_q1) begin
                mux_q <= tile_q[rd_row_q1];
            end
            o_rsp_valid <= rd_vld_q2;
            if (rd_vld_q2) begin
                o_rsp_data <= mux_q;
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// -----------------------------------------------------------------------------
// tb_sram_bank_array
//   Self-checking bench for sram_bank_array. A word-level model (array of
//   words, queue of expected responses with due edge numbers, ready window)
//   predicts the outputs; one process compares them on every falling edge.
//   Directed sequences pin the model with literal values, then random
//   traffic runs against it. Masked-write sequences run only when
//   SRAM_BYTE_WEN_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_bank_array;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;
    localparam int NB      = BW_DATA / 8;
    localparam int DEPTH   = 1 << BW_ADDR;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_wen = 1'b0;
    logic [BW_ADDR-1:0] req_addr = '0;
    logic [BW_DATA-1:0] req_data = '0;
    logic [NB-1:0]      req_ben = '0;
    logic               rsp_valid;
    logic [BW_DATA-1:0] rsp_data;

    always #5 clk = ~clk;

    sram_bank_array #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_wen   (req_wen),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_req_ben   (req_ben),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data)
    );

    // ---------------- model state ----------------
    typedef struct {
        int               due;
        bit               known;
        logic [BW_DATA-1:0] data;
    } rsp_t;

    rsp_t               rsp_q[$];
    logic [BW_DATA-1:0] obs_q[$];
    logic [BW_DATA-1:0] mem   [DEPTH];
    bit                 known [DEPTH];
    int                 edge_cnt   = 0;
    int                 rel_edge   = 0;
    int                 busy_until = 0;
    bit                 pend       = 1'b0;
    int                 pend_edge  = 0;
    int                 pend_addr  = 0;
    logic [BW_DATA-1:0] pend_data  = '0;
    logic [BW_DATA-1:0] last_data  = '0;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [BW_DATA-1:0] act,
                         input logic [BW_DATA-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic bit model_ready();
        return rst_n && (edge_cnt > rel_edge) && (edge_cnt >= busy_until);
    endfunction

    function automatic logic [BW_DATA-1:0] merge(input logic [BW_DATA-1:0] old_w,
                                                 input logic [BW_DATA-1:0] new_w,
                                                 input logic [NB-1:0] ben);
        logic [BW_DATA-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) if (ben[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [BW_DATA-1:0] get_obs(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 'x;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        rsp_t it;
        check("ready", {63'd0, req_ready}, {63'd0, model_ready()});
        if (!rst_n) begin
            check("rst_valid", {63'd0, rsp_valid}, 64'd0);
            check("rst_data", rsp_data, 64'd0);
        end else begin
            if (rsp_valid) obs_q.push_back(rsp_data);
            if (rsp_q.size() > 0 && rsp_q[0].due == edge_cnt) begin
                it = rsp_q.pop_front();
                check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
                if (it.known) begin
                    check("rsp_data", rsp_data, it.data);
                    last_data = it.data;
                end else begin
                    last_data = rsp_data;
                end
            end else begin
                check("idle_valid", {63'd0, rsp_valid}, 64'd0);
                check("hold_data", rsp_data, last_data);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic model_accept(input bit w, input int a, input logic [BW_DATA-1:0] d,
                                input logic [NB-1:0] ben, input int e);
        rsp_t it;
        if (!w) begin
            it.due   = e + 2;
            it.known = known[a];
            it.data  = mem[a];
            rsp_q.push_back(it);
        end else begin
`ifdef SRAM_BYTE_WEN_EN
            if (&ben) begin
                mem[a] = d; known[a] = 1'b1;
            end else if (|ben) begin
                pend       = 1'b1;
                pend_edge  = e + 3;
                pend_addr  = a;
                pend_data  = merge(mem[a], d, ben);
                busy_until = e + 3;
            end
`else
            mem[a] = d; known[a] = 1'b1;
`endif
        end
    endtask

    task automatic req(input bit v, input bit w, input int a,
                       input logic [BW_DATA-1:0] d, input logic [NB-1:0] ben);
        bit acc;
        @(negedge clk); #1;
        req_valid = v;
        req_wen   = w;
        req_addr  = BW_ADDR'(a);
        req_data  = d;
        req_ben   = ben;
        acc = v && model_ready();
        @(posedge clk); #1;
        if (pend && edge_cnt >= pend_edge) begin
            mem[pend_addr] = pend_data;
            pend = 1'b0;
        end
        if (acc) model_accept(w, a, d, ben, edge_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) req(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        rsp_q.delete();
        pend       = 1'b0;
        busy_until = 0;
        last_data  = '0;
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        rst_n    = 1'b1;
        rel_edge = edge_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW_DATA-1:0] d;
        logic [NB-1:0]      ben;
        bit                 v, w;
        int                 a;

        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; known[i] = 1'b0; end

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n    = 1'b1;
        rel_edge = edge_cnt;

        // Corner words, read back to back.
        obs_q.delete();
        req(1, 1, 'h00, 64'hDEADBEEF_01234567, '1);
        req(1, 1, 'h3F, 64'hA5A5A5A5_5A5A5A5A, '1);
        req(1, 0, 'h00, '0, '1);
        req(1, 0, 'h3F, '0, '1);
        idle(4);
        check("t2_count", 64'(obs_q.size()), 64'd2);
        check("t2_rd00", get_obs(0), 64'hDEADBEEF_01234567);
        check("t2_rd3f", get_obs(1), 64'hA5A5A5A5_5A5A5A5A);

        // Row sweep: 64 writes, then 64 consecutive reads.
        for (int i = 0; i < DEPTH; i++) req(1, 1, i, 64'(i) * 64'h01010101_01010101, '1);
        obs_q.delete();
        for (int i = 0; i < DEPTH; i++) req(1, 0, i, '0, '0);
        idle(4);
        check("t3_count", 64'(obs_q.size()), 64'd64);
        check("t3_rd0f", get_obs(15), 64'h0F0F0F0F_0F0F0F0F);
        check("t3_rd10", get_obs(16), 64'h10101010_10101010);
        check("t3_rd1f", get_obs(31), 64'h1F1F1F1F_1F1F1F1F);
        check("t3_rd20", get_obs(32), 64'h20202020_20202020);
        check("t3_rd2f", get_obs(47), 64'h2F2F2F2F_2F2F2F2F);
        check("t3_rd30", get_obs(48), 64'h30303030_30303030);

        // Write followed immediately by a read of the same word.
        obs_q.delete();
        req(1, 1, 'h05, 64'h0BADF00D_CAFE0005, '1);
        req(1, 0, 'h05, '0, '0);
        idle(4);
        check("t4_raw", get_obs(0), 64'h0BADF00D_CAFE0005);

        // Reset with reads in flight; contents must survive.
        req(1, 0, 'h01, '0, '0);
        req(1, 0, 'h02, '0, '0);
        req(1, 0, 'h03, '0, '0);
        do_reset(2);
        idle(2);
        obs_q.delete();
        req(1, 0, 'h07, '0, '0);
        idle(4);
        check("t1_keep", get_obs(0), 64'h07070707_07070707);

`ifdef SRAM_BYTE_WEN_EN
        // Masked write: low four bytes replaced.
        req(1, 1, 'h10, 64'h11223344_55667788, '1);
        req(1, 1, 'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
        idle(4);
        obs_q.delete();
        req(1, 0, 'h10, '0, '0);
        idle(4);
        check("t5_merge", get_obs(0), 64'h11223344_FFFFFFFF);
        // Empty mask leaves the word alone and does not stall.
        req(1, 1, 'h10, 64'h00000000_00000000, 8'h00);
        obs_q.delete();
        req(1, 0, 'h10, '0, '0);
        idle(4);
        check("t5_nomask", get_obs(0), 64'h11223344_FFFFFFFF);

        // Reset while the sequencer waits for read data: write is dropped.
        req(1, 1, 'h20, 64'h01234567_89ABCDEF, '1);
        req(1, 1, 'h20, 64'hFFFFFFFF_FFFFFFFF, 8'hF0);
        idle(1);
        do_reset(2);
        idle(2);
        obs_q.delete();
        req(1, 0, 'h20, '0, '0);
        idle(4);
        check("t6_dropped", get_obs(0), 64'h01234567_89ABCDEF);
`endif

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(2);
            v = ($urandom_range(0, 9) < 8);
            w = $urandom_range(0, 1) == 1;
            a = $urandom_range(0, DEPTH - 1);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       ben = '1;
                1:       ben = '0;
                default: ben = NB'($urandom);
            endcase
            req(v, w, a, d, ben);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
